// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Drains a fifo in bursts. Waits until the fifo holds BURST_LEN words (or,
//   when flush is high, whatever is stored), reads that many words and
//   presents them on a valid/ready master port. m_last marks the final word
//   of each burst. A 2-entry buffer absorbs the fifo's 1-cycle read latency
//   and downstream backpressure.
//
//   Handshake: a word transfers on a rising edge where m_valid && m_ready.
//   Once m_valid is high, it stays high and m_data/m_last stay stable until
//   that transfer happens.
//
// Ports
//   clk, reset_n     clock (rising edge), async active-low reset
//   fifo_empty       fifo empty flag
//   fifo_word_count  fifo occupancy (ADDR_WIDTH+2 bits)
//   fifo_r_data      fifo read data, valid the cycle after fifo_rd
//   fifo_rd          fifo read strobe
//   flush            level: allow a short burst of the stored words
//   m_valid/m_data/m_last/m_ready  master output port
//   busy             FSM is not idle
//   burst_count      completed bursts (zero unless FIFO_BURST_STATS_EN)
//   state_dbg        current FSM state (0 idle, 1 burst, 2 drain)
//
// Build option
//   FIFO_BURST_STATS_EN  enables the 16-bit wrapping burst counter.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH+1:0] fifo_word_count,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [15:0]           burst_count,
  output logic [1:0]            state_dbg
);

  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   rd_left, out_left, len_n;
  logic            load;
  logic            inflight;
  logic [1:0]      occ;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic            acc;

  assign acc       = m_valid && m_ready;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = buf0;
  assign m_last    = m_valid && (out_left == CW'(1));
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Only read when the word is guaranteed a buffer slot on arrival: entries
  // held plus the word already in flight, minus one leaving this cycle.
  assign fifo_rd = (state == BURST) && (rd_left != '0) && !fifo_empty &&
                   (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, acc}));

  always_comb begin
    state_n = state;
    load    = 1'b0;
    len_n   = '0;
    case (state)
      IDLE: begin
        if (fifo_word_count >= BURST_LEN_C) begin
          load    = 1'b1;
          len_n   = BURST_LEN_C;
          state_n = BURST;
        end else if (flush && (fifo_word_count != '0)) begin
          load    = 1'b1;
          len_n   = fifo_word_count;
          state_n = BURST;
        end
      end
      BURST: begin
        // Leave as the final read issues; its data lands while draining.
        if (fifo_rd && (rd_left == CW'(1))) state_n = DRAIN;
      end
      DRAIN: begin
        if (acc && m_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rd_left  <= '0;
      out_left <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_n;
      inflight <= fifo_rd;
      if (load)         rd_left <= len_n;
      else if (fifo_rd) rd_left <= rd_left - CW'(1);
      if (load)         out_left <= len_n;
      else if (acc)     out_left <= out_left - CW'(1);
    end
  end

  // Two-entry buffer: buf0 is the head shown on m_data. A capture and a
  // handshake in the same cycle shift and fill together; occ is unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({inflight, acc})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_r_data;
          else             buf1 <= fifo_r_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_r_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_r_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_BURST_STATS_EN
  logic [15:0] burst_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              burst_cnt <= 16'd0;
    else if (acc && m_last)    burst_cnt <= burst_cnt + 16'd1;
  end
  assign burst_count = burst_cnt;
`else
  assign burst_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural fifo feeding the reader, directed
// steps in one initial block, and a negedge monitor scoring the output port.
module tb_fifo_burst_reader;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int BL = 4;
  localparam int CW = AW + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_empty;
  logic [CW-1:0] fifo_word_count;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_rd;
  logic          flush = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [15:0]   burst_count;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
    .fifo_word_count(fifo_word_count), .fifo_r_data(fifo_r_data),
    .fifo_rd(fifo_rd), .flush(flush), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .burst_count(burst_count), .state_dbg(state_dbg)
  );

  // ---------------- behavioural fifo ----------------
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem [16];
  logic [3:0]    wp, rp;
  logic [CW-1:0] f_cnt;

  assign fifo_empty      = (f_cnt == '0);
  assign fifo_word_count = f_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0; rp <= '0; f_cnt <= '0; fifo_r_data <= '0;
    end else begin
      if (fifo_rd && f_cnt != '0) begin
        fifo_r_data <= mem[rp];
        rp <= rp + 4'd1;
      end
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 4'd1;
      end
      f_cnt <= f_cnt + CW'(wr_en) - CW'(fifo_rd && f_cnt != '0);
    end
  end

  // ---------------- scoreboard ----------------
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int            rd_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  int            cyc = 0;
  int            outst = 0;
  logic          busy_chk = 1'b0;
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          acc_s;
  logic [DW-1:0] e_d;
  logic          e_l;

  always @(negedge clk) begin
    if (!reset_n) begin
      outst = 0; busy_chk = 1'b0; hold_v = 1'b0;
    end else begin
      cyc++;
      if (fifo_rd) rd_cyc.push_back(cyc);
      if (busy_chk) check("busy_after_last", {31'd0, busy}, 32'd0);
      busy_chk = 1'b0;
      if (hold_v) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {28'd0, m_data}, {28'd0, hold_d});
      end
      acc_s = m_valid && m_ready;
      if (acc_s) begin
        check("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e_d = exp_q.pop_front();
          e_l = exp_last_q.pop_front();
          check("m_data", {28'd0, m_data}, {28'd0, e_d});
          check("m_last", {31'd0, m_last}, {31'd0, e_l});
        end
        if (m_last) busy_chk = 1'b1;
      end
      check("occ_limit", {31'd0, (outst + int'(fifo_rd) - int'(acc_s)) <= 2}, 32'd1);
      outst  = outst + int'(fifo_rd) - int'(acc_s);
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic last);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    exp_last_q.push_back(last);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input logic tog);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      if (tog) m_ready = ~m_ready;
      step();
      n++;
    end
    check(tag, {31'd0, n < budget}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int base;

  initial begin
    // reset state
    #1;
    check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();

    // full burst, m_ready high: 4 back-to-back reads, last on word 3
    m_ready = 1'b1;
    base = rd_cyc.size();
    for (int i = 0; i < 4; i++) push(DW'(i), i == 3);
    wait_idle("t2_idle", 40, 1'b0);
    check("t2_rd_count", rd_cyc.size() - base, 32'd4);
    check("t2_rd_b2b", rd_cyc[base+3] - rd_cyc[base], 32'd3);
    check("t2_state", {30'd0, state_dbg}, 32'd0);

    // m_ready toggling every cycle
    base = rd_cyc.size();
    for (int i = 0; i < 4; i++) push(DW'(i), i == 3);
    wait_idle("t3_idle", 60, 1'b1);
    check("t3_rd_count", rd_cyc.size() - base, 32'd4);

    // three words: no burst until flush, then short burst 0,1,2
    m_ready = 1'b1;
    base = rd_cyc.size();
    for (int i = 0; i < 3; i++) push(DW'(i), i == 2);
    for (int i = 0; i < 5; i++) step();
    check("t4_no_rd", rd_cyc.size() - base, 32'd0);
    check("t4_not_busy", {31'd0, busy}, 32'd0);
    check("t4_count", {26'd0, fifo_word_count}, 32'd3);
    flush = 1'b1;
    wait_idle("t4_idle", 40, 1'b0);
    flush = 1'b0;
    check("t4_rd_count", rd_cyc.size() - base, 32'd3);

    // backpressure: m_ready low, only two words leave the fifo
    m_ready = 1'b0;
    for (int i = 5; i < 9; i++) push(DW'(i), i == 8);
    for (int i = 0; i < 8; i++) step();
    check("t6_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    check("t6_valid", {31'd0, m_valid}, 32'd1);
    check("t6_data", {28'd0, m_data}, 32'd5);
    check("t6_last", {31'd0, m_last}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_state", {30'd0, state_dbg}, 32'd1);
    check("t6_fifo_left", {26'd0, fifo_word_count}, 32'd2);
    m_ready = 1'b1;
    wait_idle("t6_idle", 40, 1'b0);

    // reset in the middle of a stalled burst
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(i + 9), i == 3);
    for (int i = 0; i < 4; i++) step();
    check("t1_pre_valid", {31'd0, m_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t1_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    check("t1_m_valid", {31'd0, m_valid}, 32'd0);
    check("t1_m_data", {28'd0, m_data}, 32'd0);
    check("t1_m_last", {31'd0, m_last}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_burst_count", {16'd0, burst_count}, 32'd0);
    check("t1_state", {30'd0, state_dbg}, 32'd0);
    exp_q.delete();
    exp_last_q.delete();
    step(); step();
    reset_n = 1'b1;
    step();

    // sixteen words: four bursts of four
    m_ready = 1'b1;
    base = rd_cyc.size();
    for (int i = 0; i < 16; i++) push(DW'(i), (i % 4) == 3);
    wait_idle("t5_idle", 120, 1'b0);
    check("t5_rd_count", rd_cyc.size() - base, 32'd16);
`ifdef FIFO_BURST_STATS_EN
    check("t5_burst_count", {16'd0, burst_count}, 32'd4);
`else
    check("t5_burst_count", {16'd0, burst_count}, 32'd0);
`endif
    check("t5_fifo_empty", {31'd0, fifo_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
